// File: rtl/program_counter_stack_if.sv
// Control-unit <-> program counter bus: op strobes, jump/branch operands, fetch address and stack status.
interface program_counter_stack_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned OFF_W  = 4
);
    logic              en;
    logic              jmp;
    logic              brn;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] out;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err;

    modport master (
        output en, jmp, brn, call, ret, target, offset,
        input  out, stk_empty, stk_full, stk_err
    );

    modport slave (
        input  en, jmp, brn, call, ret, target, offset,
        output out, stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/program_counter_stack.sv
// Fetch-address generator: increment, jump, relative branch and call/return.
// Define PC_RET_STACK_EN to build the return-address stack; otherwise call acts as jmp and ret as increment.
module program_counter_stack #(
    parameter int unsigned            ADDR_W      = 6,
    parameter int unsigned            OFF_W       = 4,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]      RESET_VEC   = '0
) (
    input  logic                    clk,
    input  logic                    res,
    program_counter_stack_if.slave  bus
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_sext;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign off_sext = ADDR_W'($signed(bus.offset));
    assign bus.out  = pc_q;

`ifdef PC_RET_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic              err_q;
    logic              err_d;
    logic              push;
    logic              sp_zero;
    logic              sp_max;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign sp_zero = (sp_q == '0);
    assign sp_max  = (sp_q == SP_W'(STACK_DEPTH));
    assign top_idx = IDX_W'(sp_q - SP_W'(1));
    assign wr_idx  = IDX_W'(sp_q);

    // Next PC / stack pointer; priority ret > call > jmp > brn > increment
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                if (sp_zero) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = stack_mem[top_idx];
                    sp_d = sp_q - SP_W'(1);
                end
            end else if (bus.call) begin
                pc_d = bus.target;
                if (sp_max) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                end
            end else if (bus.jmp) begin
                pc_d = bus.target;
            end else if (bus.brn) begin
                pc_d = pc_q + off_sext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage is not reset; a reset-cycle push is suppressed so the stack is logically empty
    always_ff @(posedge clk) begin
        if (!res && push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign bus.stk_empty = sp_zero;
    assign bus.stk_full  = sp_max;
    assign bus.stk_err   = err_q;
`else
    // Without a stack, call degenerates to jmp and ret to increment
    always_comb begin
        pc_d = pc_q;
        if (bus.en) begin
            if (bus.ret) begin
                pc_d = pc_inc;
            end else if (bus.call || bus.jmp) begin
                pc_d = bus.target;
            end else if (bus.brn) begin
                pc_d = pc_q + off_sext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.stk_empty = 1'b1;
    assign bus.stk_full  = 1'b0;
    assign bus.stk_err   = 1'b0;
`endif
endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack; covers the stack build when PC_RET_STACK_EN is defined.
module tb_program_counter_stack;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned OFF_W  = 4;

    logic clk;
    logic res;
    int   n_chk;
    int   n_fail;

    program_counter_stack_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

    program_counter_stack #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(4), .RESET_VEC(6'h00)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one op for one clock edge, then settle past the edge
    task automatic step(input logic e, input logic j, input logic b, input logic c,
                        input logic r, input logic [ADDR_W-1:0] t, input logic [OFF_W-1:0] o);
        bus.en     = e;
        bus.jmp    = j;
        bus.brn    = b;
        bus.call   = c;
        bus.ret    = r;
        bus.target = t;
        bus.offset = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        res    = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
        check("rst_out",   32'(bus.out), 32'h00);
        check("rst_empty", 32'(bus.stk_empty), 32'h1);
        check("rst_full",  32'(bus.stk_full), 32'h0);
        check("rst_err",   32'(bus.stk_err), 32'h0);
        res = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
            check("inc_out", 32'(bus.out), 32'(i));
        end
        check("inc_empty", 32'(bus.stk_empty), 32'h1);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, 4'h0);
        check("jmp_3f", 32'(bus.out), 32'h3F);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
        check("wrap_inc", 32'(bus.out), 32'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h02, 4'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 4'hC);
        check("brn_neg_wrap", 32'(bus.out), 32'h3E);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h10, 4'h1);
        check("jmp_over_brn", 32'(bus.out), 32'h10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h2A, 4'h7);
        check("brn_pos", 32'(bus.out), 32'h17);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h2A, 4'h0);
            check("stall_out", 32'(bus.out), 32'h17);
            check("stall_err", 32'(bus.stk_err), 32'h0);
        end
        check("stall_empty", 32'(bus.stk_empty), 32'h1);

`ifdef PC_RET_STACK_EN
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h05, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h20, 4'h0);
        check("call_out",   32'(bus.out), 32'h20);
        check("call_empty", 32'(bus.stk_empty), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("ret_out",   32'(bus.out), 32'h06);
        check("ret_empty", 32'(bus.stk_empty), 32'h1);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h30, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h31, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h32, 4'h0);
        check("fill_notfull", 32'(bus.stk_full), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h33, 4'h0);
        check("fill_full", 32'(bus.stk_full), 32'h1);
        check("fill_err",  32'(bus.stk_err), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 4'h0);
        check("ovf_out",  32'(bus.out), 32'h10);
        check("ovf_full", 32'(bus.stk_full), 32'h1);
        check("ovf_err",  32'(bus.stk_err), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
        check("ovf_err_clr", 32'(bus.stk_err), 32'h0);
        check("ovf_inc", 32'(bus.out), 32'h11);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("pop3", 32'(bus.out), 32'h33);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("pop2", 32'(bus.out), 32'h32);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("pop1", 32'(bus.out), 32'h31);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("pop0", 32'(bus.out), 32'h07);
        check("pop_empty", 32'(bus.stk_empty), 32'h1);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("unf_out", 32'(bus.out), 32'h08);
        check("unf_err", 32'(bus.stk_err), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'h0);
        check("unf_err_clr", 32'(bus.stk_err), 32'h0);
        check("unf_inc", 32'(bus.out), 32'h09);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h20, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h21, 4'h0);
        check("sp2_empty", 32'(bus.stk_empty), 32'h0);
        res = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        res = 1'b0;
        check("midrst_out",   32'(bus.out), 32'h00);
        check("midrst_empty", 32'(bus.stk_empty), 32'h1);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h15, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h30, 4'h0);
        check("callret_out",   32'(bus.out), 32'h01);
        check("callret_empty", 32'(bus.stk_empty), 32'h1);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h04, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 4'h0);
        check("push_wrap", 32'(bus.out), 32'h00);
`else
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h11, 4'h0);
        check("nostk_call", 32'(bus.out), 32'h11);
        check("nostk_call_err", 32'(bus.stk_err), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 4'h0);
        check("nostk_ret", 32'(bus.out), 32'h12);
        check("nostk_ret_err", 32'(bus.stk_err), 32'h0);
        check("nostk_empty", 32'(bus.stk_empty), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h30, 4'h0);
        check("nostk_callret", 32'(bus.out), 32'h13);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h22, 4'h3);
        check("nostk_call_over_brn", 32'(bus.out), 32'h22);
        res = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h2C, 4'h0);
        res = 1'b0;
        check("nostk_midrst", 32'(bus.out), 32'h00);
        check("nostk_full", 32'(bus.stk_full), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
